// File: rtl/pktgen_pkg.sv
// Shared types and txbuf word map for the periodic UDP packet source.
// Word 0 holds dest IP, 1 holds ports, 2 holds length, payload starts at 3.
package pktgen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    LATCH,
    RELEASE,
    WAIT_TAKE,
    WAIT_DONE
  } state_e;

  localparam int TXBUF_W_IP      = 0;
  localparam int TXBUF_W_PORTS   = 1;
  localparam int TXBUF_W_LEN     = 2;
  localparam int TXBUF_W_PAYLOAD = 3;

  function automatic int payload_words(input int bytes);
    return (bytes + 3) / 4;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_i, wrapping.
// Zero latency; any_o is low when no requester is active.
module rr_arbiter #(
  parameter int N = 4,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [LW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [LW-1:0] idx;

  always_comb begin
    gnt_idx_o = last_i;
    any_o     = |req_i;
    idx       = '0;
    // Walk from farthest to nearest so the nearest requester after last_i wins.
    for (int i = N; i >= 1; i--) begin
      idx = LW'((int'(last_i) + i) % N);
      if (req_i[idx]) gnt_idx_o = idx;
    end
  end

endmodule

// File: rtl/udp_txbuf_pktgen.sv
// Round-robin periodic UDP packet source driving the txbuf CPU port via grant/release.
// Read data is registered (1 cycle); a stalled grant merges further ticks into one pending send.
module udp_txbuf_pktgen
  import pktgen_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int AWIDTH            = 6,
  parameter int MAX_PAYLOAD_BYTES = 16,
  parameter int PERIOD_W          = 32,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CH-1:0]                     ch_en,
  input  logic [NUM_CH*32-1:0]                  ch_dst_ip,
  input  logic [NUM_CH*32-1:0]                  ch_ports,
  input  logic [NUM_CH*8-1:0]                   ch_len,
  input  logic [NUM_CH*MAX_PAYLOAD_BYTES*8-1:0] ch_payload,
  input  logic [PERIOD_W-1:0]                   period,
  input  logic [AWIDTH-1:0]                     txbuf_addr,
  output logic [31:0]                           txbuf_rdata,
  input  logic                                  txbuf_cpu_grant,
  output logic                                  txbuf_cpu_rel,
  output logic                                  busy,
  output logic [CHW-1:0]                        active_ch,
  output logic [15:0]                           sent_cnt
);

  localparam int MAXB = MAX_PAYLOAD_BYTES;
  localparam int PAYW = payload_words(MAXB);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tick;
  logic                pend_q, pend_d;
  logic [CHW-1:0]      rr_q, rr_d, act_q, act_d;
  logic [CHW-1:0]      gnt_idx;
  logic                gnt_any;
  logic                busy_q, busy_d;
  logic [15:0]         sent_q, sent_d;
  logic [31:0]         ip_q, ip_d, ports_q, ports_d;
  logic [7:0]          len_q, len_d;
  logic [MAXB*8-1:0]   pay_q, pay_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [7:0]          sel_len, eff_len;
  logic [MAXB*8-1:0]   sel_pay, lat_pay;
  logic [PAYW*32-1:0]  pay_pad;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req_i     (ch_en),
    .last_i    (rr_q),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // period of 0 or 1 degenerates to a tick every cycle
  assign tick   = (period <= PERIOD_W'(1)) || (cnt_q >= period - PERIOD_W'(1));
  assign cnt_d  = tick ? '0 : cnt_q + PERIOD_W'(1);
  // IDLE always consumes the pending tick: it either starts a send or is dropped
  assign pend_d = tick || (pend_q && (state_q != IDLE));

  assign sel_len = ch_len[gnt_idx*8 +: 8];
  assign sel_pay = ch_payload[gnt_idx*(MAXB*8) +: MAXB*8];
  assign eff_len = (sel_len > 8'(MAXB)) ? 8'(MAXB) : sel_len;

  // Bytes beyond the packet length are zeroed once at snapshot time
  always_comb begin
    lat_pay = '0;
    for (int i = 0; i < MAXB; i++) begin
      if (i < int'(eff_len)) lat_pay[8*i +: 8] = sel_pay[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    sent_d  = sent_q;
    act_d   = act_q;
    rr_d    = rr_q;
    ip_d    = ip_q;
    ports_d = ports_q;
    len_d   = len_q;
    pay_d   = pay_q;
    case (state_q)
      IDLE:       if (pend_q && |ch_en) state_d = WAIT_GRANT;
      WAIT_GRANT: if (txbuf_cpu_grant) state_d = LATCH;
      LATCH: begin
        if (gnt_any) begin
          ip_d    = ch_dst_ip[gnt_idx*32 +: 32];
          ports_d = ch_ports[gnt_idx*32 +: 32];
          len_d   = eff_len;
          pay_d   = lat_pay;
          act_d   = gnt_idx;
          rr_d    = gnt_idx;
          busy_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          state_d = IDLE;
        end
      end
      RELEASE:    state_d = WAIT_TAKE;
      WAIT_TAKE:  if (!txbuf_cpu_grant) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (txbuf_cpu_grant) begin
          sent_d  = sent_q + 16'd1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    pay_pad               = '0;
    pay_pad[MAXB*8-1:0]   = pay_q;
    rdata_d               = '0;
    if (txbuf_addr == AWIDTH'(TXBUF_W_IP))         rdata_d = ip_q;
    else if (txbuf_addr == AWIDTH'(TXBUF_W_PORTS)) rdata_d = ports_q;
    else if (txbuf_addr == AWIDTH'(TXBUF_W_LEN))   rdata_d = {24'b0, len_q};
    else begin
      for (int k = 0; k < PAYW; k++) begin
        if (txbuf_addr == AWIDTH'(TXBUF_W_PAYLOAD + k)) rdata_d = pay_pad[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      rr_q    <= CHW'(NUM_CH - 1);
      act_q   <= '0;
      busy_q  <= 1'b0;
      sent_q  <= '0;
      ip_q    <= '0;
      ports_q <= '0;
      len_q   <= '0;
      pay_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
      ip_q    <= ip_d;
      ports_q <= ports_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      rdata_q <= rdata_d;
    end
  end

  assign txbuf_rdata   = rdata_q;
  assign txbuf_cpu_rel = (state_q == RELEASE);
  assign busy          = busy_q;
  assign active_ch     = act_q;
  assign sent_cnt      = sent_q;

endmodule

// File: tb/tb_udp_txbuf_pktgen.sv
// Directed bench for udp_txbuf_pktgen: round-robin order, timing, read map, stall and reset.
module tb_udp_txbuf_pktgen;

  localparam int NUM_CH   = 4;
  localparam int AWIDTH   = 6;
  localparam int MAXB     = 16;
  localparam int PERIOD_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*32-1:0]     ch_dst_ip;
  logic [NUM_CH*32-1:0]     ch_ports;
  logic [NUM_CH*8-1:0]      ch_len;
  logic [NUM_CH*MAXB*8-1:0] ch_payload;
  logic [PERIOD_W-1:0]      period;
  logic [AWIDTH-1:0]        txbuf_addr;
  logic [31:0]              txbuf_rdata;
  logic                     txbuf_cpu_grant;
  logic                     txbuf_cpu_rel;
  logic                     busy;
  logic [1:0]               active_ch;
  logic [15:0]              sent_cnt;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  udp_txbuf_pktgen #(
    .NUM_CH(NUM_CH), .AWIDTH(AWIDTH), .MAX_PAYLOAD_BYTES(MAXB), .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_dst_ip(ch_dst_ip), .ch_ports(ch_ports),
    .ch_len(ch_len), .ch_payload(ch_payload), .period(period), .txbuf_addr(txbuf_addr),
    .txbuf_rdata(txbuf_rdata), .txbuf_cpu_grant(txbuf_cpu_grant),
    .txbuf_cpu_rel(txbuf_cpu_rel), .busy(busy), .active_ch(active_ch), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [31:0] ip, input logic [31:0] ports,
                        input logic [7:0] len);
    ch_dst_ip[ch*32 +: 32] = ip;
    ch_ports[ch*32 +: 32]  = ports;
    ch_len[ch*8 +: 8]      = len;
  endtask

  task automatic set_byte(input int ch, input int i, input logic [7:0] v);
    ch_payload[(ch*MAXB + i)*8 +: 8] = v;
  endtask

  task automatic wait_rel(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (txbuf_cpu_rel) found = 1'b1;
    end
  endtask

  // Core side: take the buffer for `hold` cycles, then hand it back.
  task automatic handshake(input int hold);
    txbuf_cpu_grant = 1'b0;
    repeat (hold) @(negedge clk);
    txbuf_cpu_grant = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_core(input int n, output int nrel);
    int i;
    i    = 0;
    nrel = 0;
    while (i < n) begin
      @(negedge clk);
      i++;
      if (txbuf_cpu_rel) begin
        nrel++;
        handshake(2);
        i += 3;
      end
    end
  endtask

  task automatic read_chk(input logic [AWIDTH-1:0] a, input logic [31:0] exp, input string tag);
    txbuf_addr = a;
    @(negedge clk);
    check(tag, txbuf_rdata, exp);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rdata"}, txbuf_rdata, 32'h0);
    check({pfx, "_rel"}, {31'b0, txbuf_cpu_rel}, 32'h0);
    check({pfx, "_busy"}, {31'b0, busy}, 32'h0);
    check({pfx, "_active"}, {30'b0, active_ch}, 32'h0);
    check({pfx, "_sent"}, {16'b0, sent_cnt}, 32'h0);
  endtask

  initial begin
    logic [7:0] foo [7];
    int         seq [6];
    bit         found;
    int         nrel, t0, t1;

    foo = '{8'h66, 8'h6f, 8'h6f, 8'h62, 8'h61, 8'h72, 8'h0a};
    seq = '{0, 1, 3, 0, 1, 3};

    rst = 1'b1; ch_en = '0; ch_dst_ip = '0; ch_ports = '0; ch_len = '0; ch_payload = '0;
    period = 100; txbuf_addr = '0; txbuf_cpu_grant = 1'b1;
    set_ch(0, 32'h0a01a8c0, 32'h045704d2, 8'd7);
    for (int i = 0; i < 7; i++) set_byte(0, i, foo[i]);
    set_ch(1, 32'h0a000001, 32'h00010002, 8'd4);
    set_ch(2, 32'h0a000002, 32'h00030004, 8'd4);
    set_ch(3, 32'h0a000003, 32'h00050006, 8'd4);
    ch_en = 4'b0001;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // ch0 alone, period 100
    rst = 1'b0;
    t0  = cyc;
    wait_rel(150, found);
    t1 = cyc;
    check("first_rel_seen", {31'b0, found}, 32'h1);
    check("first_rel_latency", 32'(t1 - t0), 32'd103);
    check("busy_in_flight", {31'b0, busy}, 32'h1);
    check("active_ch0", {30'b0, active_ch}, 32'h0);
    txbuf_cpu_grant = 1'b0;
    @(negedge clk);
    check("rel_single_cycle", {31'b0, txbuf_cpu_rel}, 32'h0);
    @(negedge clk);
    read_chk(6'd0, 32'h0a01a8c0, "rd_ip");
    read_chk(6'd1, 32'h045704d2, "rd_ports");
    read_chk(6'd2, 32'h00000007, "rd_len");
    read_chk(6'd3, 32'h626f6f66, "rd_pay0");
    read_chk(6'd4, 32'h000a7261, "rd_pay1");
    read_chk(6'd5, 32'h00000000, "rd_pay2");
    check("sent_before_return", {16'b0, sent_cnt}, 32'd0);
    txbuf_cpu_grant = 1'b1;
    @(negedge clk);
    check("sent_after_return", {16'b0, sent_cnt}, 32'd1);
    check("busy_cleared", {31'b0, busy}, 32'h0);
    wait_rel(150, found);
    check("second_rel_seen", {31'b0, found}, 32'h1);
    check("rel_interval", 32'(cyc - t1), 32'd100);
    handshake(2);

    // Round robin over channels 0,1,3
    rst = 1'b1;
    repeat (2) @(negedge clk);
    period = 20; ch_en = 4'b1011; rst = 1'b0;
    for (int p = 0; p < 6; p++) begin
      wait_rel(40, found);
      check("rr_rel_seen", {31'b0, found}, 32'h1);
      check("rr_active", {30'b0, active_ch}, 32'(seq[p]));
      handshake(2);
    end
    check("rr_sent", {16'b0, sent_cnt}, 32'd6);

    // No channels enabled: ticks dropped
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ch_en = '0; rst = 1'b0;
    nrel = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txbuf_cpu_rel) nrel++;
    end
    check("idle_no_rel", 32'(nrel), 32'd0);
    check("idle_no_sent", {16'b0, sent_cnt}, 32'd0);
    ch_en = 4'b0100;
    wait_rel(23, found);
    check("enable_rel_bound", {31'b0, found}, 32'h1);
    check("enable_active2", {30'b0, active_ch}, 32'd2);
    handshake(2);
    check("enable_sent", {16'b0, sent_cnt}, 32'd1);

    // Core holds the buffer for 500 cycles; ticks collapse into one pending send
    period = 10;
    wait_rel(30, found);
    check("stall_rel_seen", {31'b0, found}, 32'h1);
    txbuf_cpu_grant = 1'b0;
    nrel = 0;
    repeat (500) begin
      @(negedge clk);
      if (txbuf_cpu_rel) nrel++;
    end
    check("stall_no_extra_rel", 32'(nrel), 32'd0);
    check("stall_sent_held", {16'b0, sent_cnt}, 32'd1);
    check("stall_busy", {31'b0, busy}, 32'h1);
    txbuf_cpu_grant = 1'b1;
    period = 1000;
    @(negedge clk);
    check("stall_sent_inc", {16'b0, sent_cnt}, 32'd2);
    run_core(200, nrel);
    check("pending_collapsed", 32'(nrel), 32'd1);
    check("pending_sent", {16'b0, sent_cnt}, 32'd3);

    // Length clamp and snapshot isolation
    set_ch(2, 32'hc0a80002, 32'h11223344, 8'd40);
    for (int i = 0; i < MAXB; i++) set_byte(2, i, 8'(8'h10 + i));
    period = 20;
    wait_rel(40, found);
    check("clamp_rel_seen", {31'b0, found}, 32'h1);
    check("clamp_active2", {30'b0, active_ch}, 32'd2);
    txbuf_cpu_grant = 1'b0;
    @(negedge clk);
    for (int i = 0; i < MAXB; i++) set_byte(2, i, 8'hff);
    set_ch(2, 32'hdeadbeef, 32'h55667788, 8'd3);
    @(negedge clk);
    read_chk(6'd2, 32'h00000010, "clamp_len");
    read_chk(6'd3, 32'h13121110, "snap_pay0");
    read_chk(6'd6, 32'h1f1e1d1c, "snap_pay3");
    read_chk(6'd7, 32'h00000000, "past_payload");
    read_chk(6'd0, 32'hc0a80002, "snap_ip");
    txbuf_cpu_grant = 1'b1;
    @(negedge clk);
    check("clamp_sent", {16'b0, sent_cnt}, 32'd4);

    // Reset while the core holds the buffer
    wait_rel(40, found);
    check("rst_rel_seen", {31'b0, found}, 32'h1);
    txbuf_cpu_grant = 1'b0;
    txbuf_addr = 6'd0;
    @(negedge clk);
    check("rst_busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0; txbuf_cpu_grant = 1'b1; ch_en = 4'b0101; period = 20;
    wait_rel(40, found);
    check("resume_rel_seen", {31'b0, found}, 32'h1);
    check("resume_active0", {30'b0, active_ch}, 32'd0);
    handshake(2);
    read_chk(6'd0, 32'h0a01a8c0, "resume_ip");
    check("resume_sent", {16'b0, sent_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/udp_txbuf_pktgen.md
Name: udp_txbuf_pktgen

Overview:
- Parametrised periodic UDP packet source for the ros2_ether udp_txbuf CPU-side port.
- Successor to the hard-coded single-packet txbuf driver in the example top.
- Serves NUM_CH independently configured packet templates (dest IP, ports, payload) in round-robin order, one per period tick.
- Owns the grant/release handshake and answers txbuf_addr reads with a registered word.

Parameters:
- NUM_CH, 4, number of packet templates (1..8).
- AWIDTH, 6, txbuf word address width (= UDP_TXBUF_AWIDTH).
- MAX_PAYLOAD_BYTES, 16, payload bytes per template; 3 + ceil(MAX/4) must be <= 2^AWIDTH.
- PERIOD_W, 32, period counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ch_en  in  NUM_CH  per-channel enable
- ch_dst_ip  in  NUM_CH*32  txbuf word 0 per channel
- ch_ports  in  NUM_CH*32  txbuf word 1 per channel, {dst_port, src_port}
- ch_len  in  NUM_CH*8  payload length in bytes
- ch_payload  in  NUM_CH*MAX_PAYLOAD_BYTES*8  payload; byte i at bits [8i+7:8i]
- period  in  PERIOD_W  clocks between send attempts
- txbuf_addr  in  AWIDTH  word address from core
- txbuf_rdata  out  32  registered read data
- txbuf_cpu_grant  in  1  high = CPU owns txbuf
- txbuf_cpu_rel  out  1  one-cycle release pulse
- busy  out  1  packet in flight
- active_ch  out  $clog2(NUM_CH) (min 1)  channel currently or last sent
- sent_cnt  out  16  packets completed, wraps

Behaviour:
- Reset values: txbuf_rdata=0, txbuf_cpu_rel=0, busy=0, active_ch=0, sent_cnt=0. Also period counter=0, tick_pend=0, rr pointer=NUM_CH-1, state IDLE.
- Period counter: counts 0..period-1; emits tick on wrap. period=0 or 1 gives a tick every cycle.
- tick_pend: set by tick, cleared on leaving IDLE. A tick while non-IDLE is merged into tick_pend, not queued.
- FSM:
  - IDLE: when tick_pend and any ch_en bit is set, go to WAIT_GRANT. Ticks with no channel enabled are dropped silently.
  - WAIT_GRANT: wait for grant=1, then go to LATCH.
  - LATCH (1 cycle): the arbiter picks the first enabled channel after rr pointer, with wrap-around. Snapshot that channel's ip/ports/len/payload into holding registers; set active_ch and rr pointer; set busy=1. If ch_en changed and no channel is enabled now, return to IDLE.
  - RELEASE (1 cycle): txbuf_cpu_rel=1.
  - WAIT_TAKE: wait for grant=0.
  - WAIT_DONE: on grant=1, increment sent_cnt, set busy=0, go to IDLE.
- Config changes after LATCH do not affect the in-flight packet.
- Length: effective len = min(ch_len, MAX_PAYLOAD_BYTES), latched at LATCH.
- Read port: every cycle, txbuf_rdata <= f(txbuf_addr) from the holding registers (1-cycle latency), in all states.
  - addr 0 = ip.
  - addr 1 = ports.
  - addr 2 = {24'b0, len}.
  - addr 3+k = payload bytes 4k..4k+3, byte 4k in bits [7:0].
  - Bytes with index >= len read 0.
  - Addresses >= 3 + ceil(MAX/4) read 0.
- Reset mid-operation: the FSM returns to IDLE and no rel pulse is produced in the reset cycle.
- sent_cnt wraps 0xFFFF -> 0.

Decomposition:
- Package pktgen_pkg holds:
  - FSM state enum (IDLE, WAIT_GRANT, LATCH, RELEASE, WAIT_TAKE, WAIT_DONE)
  - TXBUF_W_IP=0, TXBUF_W_PORTS=1, TXBUF_W_LEN=2, TXBUF_W_PAYLOAD=3
  - a function for payload word count
- Sub-module rr_arbiter: parameter N. Inputs req[N] and last[log2N]. Outputs gnt_idx and any. Purely combinational and reusable.

Test Plan:
- ch0 only: ip=0x0a01a8c0, ports=0x045704d2, len=7, payload "foobar\n", period=100 -> one rel pulse per 100 clk. Reads of addr 0..5 return 0x0a01a8c0, 0x045704d2, 0x00000007, 0x626f6f66, 0x000a7261, 0. sent_cnt increments after grant returns.
- ch_en=4'b1011, period=20 -> active_ch sequence 0,1,3,0,1,3; ch2 is never sent.
- ch_en=0 with period running -> txbuf_cpu_rel stays 0 and sent_cnt stays 0 for 1000 clk. Setting ch_en[2]=1 gives the first rel within period+3 clk.
- Grant held low for 500 clk with period=10 -> exactly one rel, then one sent_cnt increment when grant rises. Queued ticks collapse to a single pending send.
- ch_len=40 with MAX=16 -> addr 2 reads 16. Changing ch_payload during WAIT_TAKE -> reads still return the latched bytes.
- rst asserted during WAIT_TAKE -> next cycle all outputs are at reset values and state is IDLE. After release, normal sends resume with active_ch starting at 0.
